// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU memory-port sequencer.
// Provides the sequencer state encoding, the requester id encoding and the
// default bus widths used by mem_access_ctrl and rr_arb2.
package cpu_mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter between instruction fetch and load/store.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   if_req, ls_req  request levels
//   take            grant is being consumed this cycle (updates history)
//   gnt_vld         at least one request pending
//   gnt_id          winning requester
// last_grant resets to LS so that IF wins the first tie.
module rr_arb2
  import cpu_mem_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    if_req,
  input  logic    ls_req,
  input  logic    take,
  output logic    gnt_vld,
  output req_id_t gnt_id
);

  req_id_t last_grant;

  always_comb begin
    gnt_vld = if_req | ls_req;
    if (if_req && ls_req)
      gnt_id = (last_grant == REQ_LS) ? REQ_IF : REQ_LS;
    else if (if_req)
      gnt_id = REQ_IF;
    else
      gnt_id = REQ_LS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_grant <= REQ_LS;
    else if (take && gnt_vld)
      last_grant <= gnt_id;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences the single memory port between instruction fetch (IF) and
// load/store (LS), and owns the data register holding the last read result.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   if_req/if_addr/if_ack            fetch request, address, completion pulse
//   ls_req/ls_we/ls_addr/ls_wdata    load/store request and operands
//   ls_ack                           load/store completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata memory command (registered)
//   mem_rdata                        memory read data, valid in last ACCESS cycle
//   rd_data                          last read result, held until next read
//   busy                             sequencer not idle
// Each transfer takes MEM_LAT+2 cycles: grant, MEM_LAT access cycles, ack.
module mem_access_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy
);

  localparam int CNT_W = 4;

  state_t          state;
  req_id_t         cur_id;
  logic [CNT_W-1:0] cnt;
  logic            gnt_vld;
  req_id_t         gnt_id;

  // Arbiter history only advances when the grant is actually taken in IDLE.
  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .if_req  (if_req),
    .ls_req  (ls_req),
    .take    (state == ST_IDLE),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cur_id    <= REQ_IF;
      cnt       <= '0;
      if_ack    <= 1'b0;
      ls_ack    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_data   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            state  <= ST_ACCESS;
            cur_id <= gnt_id;
            cnt    <= CNT_W'(MEM_LAT - 1);
            mem_en <= 1'b1;
            // Requester operands are latched here and ignored afterwards.
            if (gnt_id == REQ_IF) begin
              mem_addr  <= if_addr;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
            end else begin
              mem_addr  <= ls_addr;
              mem_we    <= ls_we;
              mem_wdata <= ls_wdata;
            end
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            state  <= ST_DONE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (!mem_we)
              rd_data <= mem_rdata;
            if (cur_id == REQ_IF)
              if_ack <= 1'b1;
            else
              ls_ack <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          if_ack <= 1'b0;
          ls_ack <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if_ack <= 1'b0;
          ls_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule
